// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the active-low one-hot select decode.
package rr_arbiter8_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Active-low one-hot select, same encoding as a 3-to-8 decoder output.
  function automatic logic [NREQ-1:0] onehot_n(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin pick: rotate req so that ptr lands on bit 0,
// take the lowest set bit, then add ptr back (mod 8) to get the real index.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] pos;

  // rot[gi] is the requester gi places after ptr; the 3-bit sum wraps mod 8.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot[gi] = req[ptr + IDX_W'(gi)];
    end
  endgenerate

  // Fixed priority on the rotated vector: lowest set bit wins.
  always_comb begin
    pos = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = IDX_W'(i);
    end
  end

  assign any = |req;
  assign idx = ptr + pos;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a hold timer. One owner at a time,
// always passing through IDLE between owners so grant_n is 8'hFF for at least
// one cycle (break-before-make). All outputs are registered.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [NREQ-1:0]  grant_n,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             valid_reg, valid_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [NREQ-1:0]  grant_n_reg, grant_n_next;
  logic             timeout_reg, timeout_next;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             release_now;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_req   = req[idx_reg];
  assign release_now = done || !owner_req || (cnt_reg == HOLD_LAST);

  // State and output registers; reset takes effect immediately, even mid-grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      valid_reg   <= 1'b0;
      idx_reg     <= '0;
      grant_n_reg <= '1;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      valid_reg   <= valid_next;
      idx_reg     <= idx_next;
      grant_n_reg <= grant_n_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state and next-output logic; grant outputs are frozen while in GRANT.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    valid_next   = valid_reg;
    idx_next     = idx_reg;
    grant_n_next = grant_n_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (pick_any) begin
          state_next   = ST_GRANT;
          valid_next   = 1'b1;
          idx_next     = pick_idx;
          grant_n_next = onehot_n(pick_idx);
        end
      end
      ST_GRANT: begin
        // Saturating counter: never wraps back to a fresh hold window.
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        if (release_now) begin
          state_next   = ST_IDLE;
          valid_next   = 1'b0;
          idx_next     = '0;
          grant_n_next = '1;
          cnt_next     = '0;
          ptr_next     = idx_reg + 1'b1;
          // Only a forced revoke pulses timeout; done or a dropped request wins.
          timeout_next = !done && owner_req;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign grant_valid = valid_reg;
  assign grant_idx   = idx_reg;
  assign grant_n     = grant_n_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: the stimulus process runs a behavioural
// model each cycle and queues the expected outputs; a monitor compares them
// against the DUT after each rising edge.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 15;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic [7:0] gn;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_n;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // model state
  bit m_busy  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_held  = 0;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_n     (grant_n),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] sel_n(input int k);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << k);
  endfunction

  function automatic exp_t idle_exp(input logic to);
    exp_t e;
    e.valid = 1'b0; e.idx = 3'd0; e.gn = 8'hFF; e.to = to;
    return e;
  endfunction

  // Reference: given this cycle's inputs, what the outputs are after the edge.
  task automatic model_step();
    exp_t e;
    bit   found;
    int   k;
    if (!m_busy) begin
      found = 0;
      k = 0;
      for (int j = 0; j < 8; j++) begin
        if (!found && req[(m_ptr + j) % 8]) begin
          found = 1;
          k = (m_ptr + j) % 8;
        end
      end
      if (found) begin
        m_busy = 1; m_owner = k; m_held = 0;
        e.valid = 1'b1; e.idx = 3'(k); e.gn = sel_n(k); e.to = 1'b0;
      end else begin
        e = idle_exp(1'b0);
      end
    end else begin
      m_held++;
      if (done || !req[m_owner] || m_held >= MAX_HOLD) begin
        e = idle_exp(!done && req[m_owner]);
        m_ptr  = (m_owner + 1) % 8;
        m_busy = 0;
      end else begin
        e.valid = 1'b1; e.idx = 3'(m_owner); e.gn = sel_n(m_owner); e.to = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    @(negedge clk);
    rst  = 1'b0;
    req  = r;
    done = d;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per edge once the scoreboard is running.
  initial begin
    bit prev_valid;
    exp_t e;
    prev_valid = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_valid", 32'(grant_valid), 32'(e.valid));
        chk("grant_idx",   32'(grant_idx),   32'(e.idx));
        chk("grant_n",     32'(grant_n),     32'(e.gn));
        chk("timeout",     32'(timeout),     32'(e.to));
        if (e.valid && !prev_valid)
          $display("grant idx=%0d grant_n=%h t=%0t", e.idx, e.gn, $time);
        if (e.to)
          $display("timeout revoke t=%0t", $time);
        prev_valid = e.valid;
      end
    end
  end

  initial begin
    logic [7:0] rs;
    logic [7:0] flip;
    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset_valid", 32'(grant_valid), 32'd0);
    chk("reset_idx",   32'(grant_idx),   32'd0);
    chk("reset_gn",    32'(grant_n),     32'hFF);
    chk("reset_to",    32'(timeout),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All requesting, done pulsed each grant: 0..7,0 with an IDLE gap
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0); settle();
      chk("rr_seq_idx", 32'(grant_idx), 32'(i % 8));
      step(8'hFF, 1'b1); settle();
      chk("rr_gap_valid", 32'(grant_valid), 32'd0);
    end

    // Sole requester 3 held: 15 cycles of F7, timeout once, regrant
    step(8'h08, 1'b0); settle();
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("hold_gn", 32'(grant_n), 32'hF7);
      step(8'h08, 1'b0); settle();
    end
    chk("hold_timeout", 32'(timeout), 32'd1);
    chk("hold_idle", 32'(grant_valid), 32'd0);
    step(8'h08, 1'b0); settle();
    chk("regrant_idx", 32'(grant_idx), 32'd3);
    chk("regrant_to", 32'(timeout), 32'd0);

    // done coinciding with expiry: no pulse, release on time
    for (int i = 1; i < MAX_HOLD; i++) begin
      step(8'h08, 1'b0); settle();
    end
    chk("expiry_still_valid", 32'(grant_valid), 32'd1);
    step(8'h08, 1'b1); settle();
    chk("done_wins_to", 32'(timeout), 32'd0);
    chk("done_wins_valid", 32'(grant_valid), 32'd0);

    // Grant 6, then 0 and 6 request: search wraps past 7 to 0
    step(8'h40, 1'b0); settle();
    chk("grant6", 32'(grant_idx), 32'd6);
    step(8'h40, 1'b1); settle();
    step(8'h41, 1'b0); settle();
    chk("wrap_idx", 32'(grant_idx), 32'd0);
    step(8'h41, 1'b1); settle();

    // req[2] drops mid-grant: release next edge, ptr becomes 3
    step(8'h04, 1'b0); settle();
    chk("grant2", 32'(grant_idx), 32'd2);
    step(8'h04, 1'b0); settle();
    step(8'h00, 1'b0); settle();
    chk("drop_release", 32'(grant_valid), 32'd0);
    step(8'h0C, 1'b0); settle();
    chk("ptr3_idx", 32'(grant_idx), 32'd3);

    // Asynchronous reset mid-grant of requester 5
    step(8'h0C, 1'b1); settle();
    step(8'h20, 1'b0); settle();
    chk("grant5", 32'(grant_idx), 32'd5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gn", 32'(grant_n), 32'hFF);
    chk("async_rst_valid", 32'(grant_valid), 32'd0);
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    exp_q.push_back(idle_exp(1'b0));
    step(8'h01, 1'b0); settle();
    chk("post_rst_idx", 32'(grant_idx), 32'd0);
    step(8'h01, 1'b1); settle();

    // Randomized sticky requests with occasional done
    rs = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rs = rs ^ flip;
      step(rs, ($urandom_range(0, 15) == 0));
    end
    repeat (3) step(8'h00, 1'b0);
    settle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
